// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO between the AHB-Lite slave front end and the SPI master
// engine. Pointers carry one extra wrap bit so full and empty can be told
// apart. Flags, occupancy and read data are all registered: no input reaches
// an output combinationally.
module bridge_sync_fifo #(
    parameter int DATA_WIDTH = 41,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  push_ok;
    logic                  pop_ok;

    // Accept/reject decisions use the flags registered at the start of the cycle.
    always_comb begin
        push_ok     = wr_en && !full_q;
        pop_ok      = rd_en && !empty_q;
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;

        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rd_data_d   = pop_ok  ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;

        // Flags are precomputed from the next pointers so they land on the
        // same edge as the pointer update.
        count_d     = wr_ptr_d - rd_ptr_d;
        empty_d     = (wr_ptr_d == rd_ptr_d);
        full_d      = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    end

    // Storage array; deliberately not reset, contents are don't-care after reset.
    always_ff @(posedge rd_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointers, flags, pulses and read data register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_bridge_sync_fifo.sv
// Bench for bridge_sync_fifo: a queue-based reference model is compared with
// the DUT one ns after every rising edge, and directed scenarios add literal
// expectations that pin the model itself.
module tb_bridge_sync_fifo;

    localparam int DW    = 41;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks;
    int n_fail;

    logic [DW-1:0] q [$];
    logic [DW-1:0] m_rd_data;
    logic          m_ovf;
    logic          m_unf;

    bridge_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .rd_clk    (clk),
        .rd_rst_n  (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue size, flags come from the size
    // at the start of the cycle; then the DUT is compared 1 ns after the edge.
    always @(posedge clk) begin
        int sz;
        if (!rst_n) begin
            q.delete();
            m_rd_data = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            sz = q.size();
            m_ovf = wr_en && (sz == DEPTH);
            m_unf = rd_en && (sz == 0);
            if (rd_en && sz != 0) m_rd_data = q.pop_front();
            if (wr_en && sz != DEPTH) q.push_back(wr_data);
        end
        #1;
        chk("m_rd_data",   64'(rd_data),   64'(m_rd_data));
        chk("m_count",     64'(count),     64'(q.size()));
        chk("m_empty",     64'(empty),     64'(q.size() == 0));
        chk("m_full",      64'(full),      64'(q.size() == DEPTH));
        chk("m_overflow",  64'(overflow),  64'(m_ovf));
        chk("m_underflow", 64'(underflow), 64'(m_unf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [63:0] rnd;
        int pushed;
        int budget;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;

        // Reset held three cycles
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rdata", 64'(rd_data), 64'd0);
        chk("rst_pulse", 64'({overflow, underflow}), 64'd0);
        tick();

        // Single word, 1-cycle read latency
        wr_en = 1'b1;
        wr_data = 41'h1_2345_6789_A;
        tick();
        chk("sw_empty", 64'(empty), 64'd0);
        chk("sw_count", 64'(count), 64'd1);
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        chk("sw_rdata", 64'(rd_data), 64'h1_2345_6789_A);
        chk("sw_empty2", 64'(empty), 64'd1);
        chk("sw_count2", 64'(count), 64'd0);
        idle();

        // Fill, then a rejected 17th push
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(i);
            tick();
        end
        chk("fill_full",  64'(full),  64'd1);
        chk("fill_count", 64'(count), 64'd16);
        wr_data = DW'(99);
        tick();
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        idle();
        tick();
        chk("ovf_oneshot", 64'(overflow), 64'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_data", 64'(rd_data), 64'(i));
        end
        idle();

        // Pop while empty
        rd_en = 1'b1;
        tick();
        chk("unf_pulse", 64'(underflow), 64'd1);
        chk("unf_rdata", 64'(rd_data), 64'd15);
        idle();
        tick();
        chk("unf_oneshot", 64'(underflow), 64'd0);
        chk("unf_count", 64'(count), 64'd0);

        // Simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(100 + i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = DW'(105 + i);
            tick();
            chk("sim5_count", 64'(count), 64'd5);
            chk("sim5_data", 64'(rd_data), 64'(100 + i));
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sim5_drain", 64'(rd_data), 64'(103 + i));
        end
        idle();

        // Simultaneous push/pop while empty
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = DW'(200);
        tick();
        chk("sime_count", 64'(count), 64'd1);
        chk("sime_unf", 64'(underflow), 64'd1);
        rd_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            wr_data = DW'(200 + i);
            tick();
        end
        chk("simf_full", 64'(full), 64'd1);

        // Simultaneous push/pop while full
        rd_en = 1'b1;
        wr_data = DW'(300);
        tick();
        chk("simf_count", 64'(count), 64'd15);
        chk("simf_ovf", 64'(overflow), 64'd1);
        chk("simf_data", 64'(rd_data), 64'd200);
        wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("simf_drain", 64'(rd_data), 64'(200 + i));
        end
        idle();
        tick();
        chk("simf_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-clock with data held
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(400 + i);
            tick();
        end
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_full",  64'(full),  64'd0);
        chk("arst_rdata", 64'(rd_data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Random stream of 100 words, wrapping pointers several times
        pushed = 0;
        budget = 2000;
        while ((pushed < 100 || q.size() != 0) && budget > 0) begin
            rnd = {$urandom, $urandom};
            wr_en = (pushed < 100) && ($urandom_range(0, 3) != 0);
            wr_data = rnd[DW-1:0];
            rd_en = ($urandom_range(0, 2) != 0) || (pushed >= 100);
            if (wr_en && q.size() < DEPTH) pushed++;
            tick();
            budget--;
        end
        idle();
        chk("rand_budget", 64'(budget > 0), 64'd1);
        tick();
        chk("rand_empty", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_sync_fifo.md
# bridge_sync_fifo

Single-clock FIFO buffering 41-bit packed transfer words between the AHB-Lite slave front end and the SPI master engine of the bridge. Producer pushes with `wr_en`; consumer pops with `rd_en`. Flags and read data are registered, and the read-side signals (`rd_en`, `rd_data`, `empty`) keep the names used by the FIFO read interface.

## Interface
- `DATA_WIDTH`, 41, width of each stored word.
- `ADDR_WIDTH`, 4, pointer width; depth = 2**ADDR_WIDTH (16).
- `rd_clk` input 1: the single clock; all logic is on its rising edge.
- `rd_rst_n` input 1: reset; one clock; reset is asynchronous and active-low.
- `wr_en` input 1: push request.
- `wr_data` input DATA_WIDTH: word to push.
- `full` output 1: FIFO holds `DEPTH` words.
- `rd_en` input 1: pop request.
- `rd_data` output DATA_WIDTH: registered popped word.
- `empty` output 1: FIFO holds 0 words.
- `count` output ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse on a rejected push.
- `underflow` output 1: one-cycle pulse on a rejected pop.

## Operation
- Storage: DEPTH x DATA_WIDTH register array, not reset.
- Pointers: `wr_ptr` and `rd_ptr`, ADDR_WIDTH+1 bits each. The MSB is the wrap bit. The low bits index the array, and both pointers wrap naturally modulo 2*DEPTH.
- Accepted push: `wr_en && !full`. Write `wr_data` to `mem[wr_ptr[ADDR_WIDTH-1:0]]`, then increment `wr_ptr`.
- Accepted pop: `rd_en && !empty`. Load `rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]]`, then increment `rd_ptr`.
- `empty` = (`wr_ptr == rd_ptr`), derived from the registered pointers.
- `full` = (low bits equal and MSBs differ).
- `count` = `wr_ptr - rd_ptr`, modulo 2**(ADDR_WIDTH+1).
- Flag decisions in a cycle use the flag values present at the start of that cycle.
- Push and pop in the same cycle:
  - Neither full nor empty: both accepted, `count` unchanged.
  - Empty: only the push is accepted; `underflow` pulses.
  - Full: only the pop is accepted; `overflow` pulses.
- Rejected push: no state change except the `overflow` pulse.
- Rejected pop: no state change except the `underflow` pulse. `rd_data` holds its previous value.
- `rd_data` holds its last popped value until the next accepted pop.
- Reset values (asserted asynchronously, released synchronously):
  - `wr_ptr = rd_ptr = 0`
  - `rd_data = 0`
  - `empty = 1`, `full = 0`, `count = 0`
  - `overflow = underflow = 0`
- Reset mid-operation discards all contents immediately. Array contents are don't-care afterwards.

## Timing
- Push at edge N: `empty` deasserts and `count` increments after edge N. The word is poppable with `rd_en` sampled at edge N+1.
- Read latency is 1 cycle. `rd_en` sampled at edge N puts the word on `rd_data` after edge N, so it is valid for sampling at edge N+1. This is not first-word-fall-through.
- `full`, `empty` and `count` update after the same edge as the pointer change. There is no combinational path from `wr_en`/`rd_en` to any output.
- `overflow`/`underflow` are asserted for exactly the cycle following the offending edge.
- Inputs must be stable around the rising edge. The bench drives and samples with a 1 ns skew from the edge.

## Test plan
- **Reset:** hold `rd_rst_n=0` for 3 cycles, then release.
  - Required: `empty=1`, `full=0`, `count=0`, `rd_data=0`, no pulses.
  - Assert reset asynchronously mid-clock: outputs return to these values before the next edge.
- **Single word:** push `41'h1_2345_6789_A` at edge N.
  - Required: `empty=0` and `count=1` after edge N.
  - `rd_en` at edge N+1 gives `rd_data=41'h1_2345_6789_A`, `empty=1`, `count=0` after that edge.
- **Fill and overflow:** push 16 words 0..15.
  - Required: `full=1`, `count=16`.
  - 17th push (value 99) gives an `overflow` pulse and `count` stays 16.
  - 16 pops return 0..15 in order; 99 never appears.
- **Underflow:** `rd_en` while empty.
  - Required: `underflow` one-cycle pulse; `rd_data` keeps its previous value; pointers unchanged.
- **Simultaneous push/pop:**
  - At `count=5`: `count` stays 5 and data order is preserved.
  - While empty: `count` becomes 1 and `underflow` pulses.
  - While full: `count` becomes 15, `overflow` pulses, and the pushed word is discarded.
- **Wrap-around:** stream 100 words with random `wr_en`/`rd_en` against a scoreboard queue.
  - Required: output order matches, `count` equals the queue size every cycle, and pointers wrap past 31 with no corruption.
